// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and frame sizing.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  // Bits per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra pointer MSB to tell full from empty; exposes occupancy.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wr_ptr_q, wr_ptr_d;
  logic [Aw:0]      rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];

  // A push while full is dropped even if a pop happens on the same edge.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (Aw+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (Aw+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: TX FIFO, configurable width/parity/stop bits, run-time divisor.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_i,
  input  logic [DATA_BITS-1:0]        dat_i,
  input  logic [DIV_W-1:0]            divisor,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        ovf
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : gen_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2, at least 2");
  end

  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
  localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     baud_q, baud_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ovf_q, ovf_d;

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_empty, fifo_full;
  logic                 bit_end, load_frame;
  logic [DIV_W-1:0]     div_eff;

  uart_sync_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_i),
    .wdata_i (dat_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign div_eff = (divisor == '0) ? DIV_W'(1) : divisor;
  assign bit_end = (baud_q == '0);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    div_d      = div_q;
    baud_d     = baud_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fifo_pop   = 1'b0;
    load_frame = 1'b0;
    // Baud counter counts down and reloads on every bit boundary.
    if (state_q != StIdle) baud_d = bit_end ? div_q - DIV_W'(1) : baud_q - DIV_W'(1);
    unique case (state_q)
      StIdle:  load_frame = ~fifo_empty;
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == LastData) begin
            idx_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IdxW'(1);
            tx_d    = shift_q[1];
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q == LastStop) begin
            if (fifo_empty) state_d = StIdle;
            else            load_frame = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Frame start: latch character, parity and divisor so mid-frame changes are ignored.
    if (load_frame) begin
      fifo_pop = 1'b1;
      state_d  = StStart;
      tx_d     = 1'b0;
      div_d    = div_eff;
      baud_d   = div_eff - DIV_W'(1);
      shift_d  = fifo_rdata;
      par_d    = (^fifo_rdata) ^ (PARITY == PARITY_ODD);
    end
  end

  assign ovf_d = wr_i & fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      div_q   <= DIV_W'(1);
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != StIdle);
  assign full    = fifo_full;
  assign empty   = fifo_empty;
  assign ovf     = ovf_q;

endmodule
